// File: rtl/decode_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue_pkg
//  Description : Opcode/function constants, operation enum and queue entry
//                type shared by the decode queue and its decoder core.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_queue_pkg;

    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;

    localparam logic [6:0] FUNC7_ZERO = 7'b0000000;
    localparam logic [6:0] FUNC7_ALT  = 7'b0100000;
    localparam logic [6:0] FUNC7_MUL  = 7'b0000001;

    typedef logic [4:0] reg_pos_t;

    typedef enum logic [5:0] {
        OPENUM_NOP,
        OPENUM_LUI, OPENUM_AUIPC, OPENUM_JAL, OPENUM_JALR,
        OPENUM_BEQ, OPENUM_BNE, OPENUM_BLT, OPENUM_BGE, OPENUM_BLTU, OPENUM_BGEU,
        OPENUM_LB, OPENUM_LH, OPENUM_LW, OPENUM_LBU, OPENUM_LHU,
        OPENUM_SB, OPENUM_SH, OPENUM_SW,
        OPENUM_ADDI, OPENUM_SLTI, OPENUM_SLTIU, OPENUM_XORI, OPENUM_ORI, OPENUM_ANDI,
        OPENUM_SLLI, OPENUM_SRLI, OPENUM_SRAI,
        OPENUM_ADD, OPENUM_SUB, OPENUM_SLL, OPENUM_SLT, OPENUM_SLTU,
        OPENUM_XOR, OPENUM_SRL, OPENUM_SRA, OPENUM_OR, OPENUM_AND,
        OPENUM_MUL, OPENUM_MULH, OPENUM_MULHSU, OPENUM_MULHU,
        OPENUM_DIV, OPENUM_DIVU, OPENUM_REM, OPENUM_REMU
    } openum_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

endpackage
`default_nettype wire

// File: rtl/decode_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue_if
//  Description : Fetch-side push and issue-side pop handshakes of the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_queue_if;
    import decode_queue_pkg::*;

    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    openum_t     out_openum;
    reg_pos_t    out_rd;
    reg_pos_t    out_rs1;
    reg_pos_t    out_rs2;
    logic [31:0] out_imm;
    logic        out_illegal;

    modport master (
        output in_valid, in_pc, in_inst, out_ready,
        input  in_ready, out_valid, out_pc, out_openum, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal
    );

    modport slave (
        input  in_valid, in_pc, in_inst, out_ready,
        output in_ready, out_valid, out_pc, out_openum, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_queue_inst_decode_core.sv
`default_nettype none
// ============================================================================
//  Module      : inst_decode_core
//  Description : Combinational RV32I(+M) decoder with illegal-encoding flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_decode_core
    import decode_queue_pkg::*;
#(
    parameter bit ENABLE_M = 1'b0
) (
    input  logic [31:0] i_inst,
    output openum_t     o_openum,
    output reg_pos_t    o_rd,
    output reg_pos_t    o_rs1,
    output reg_pos_t    o_rs2,
    output logic [31:0] o_imm,
    output logic        o_illegal
);
    logic [6:0] w_opcode;
    logic [2:0] w_func3;
    logic [6:0] w_func7;
    openum_t    w_op;
    reg_pos_t   w_rd;
    reg_pos_t   w_rs1;
    reg_pos_t   w_rs2;
    logic [31:0] w_imm;
    logic       w_illegal;

    assign w_opcode = i_inst[6:0];
    assign w_func3  = i_inst[14:12];
    assign w_func7  = i_inst[31:25];

    always_comb begin
        w_op      = OPENUM_NOP;
        w_rd      = i_inst[11:7];
        w_rs1     = i_inst[19:15];
        w_rs2     = 5'd0;
        w_imm     = 32'd0;
        w_illegal = 1'b0;
        case (w_opcode)
            OPCODE_LUI, OPCODE_AUIPC: begin
                w_op  = (w_opcode == OPCODE_LUI) ? OPENUM_LUI : OPENUM_AUIPC;
                w_rs1 = 5'd0;
                w_imm = {i_inst[31:12], 12'b0};
            end
            OPCODE_JAL: begin
                w_op  = OPENUM_JAL;
                w_rs1 = 5'd0;
                w_imm = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
            end
            OPCODE_JALR: begin
                w_op      = OPENUM_JALR;
                w_imm     = {{20{i_inst[31]}}, i_inst[31:20]};
                w_illegal = (w_func3 != 3'd0);
            end
            OPCODE_LOAD: begin
                w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
                case (w_func3)
                    3'd0:    w_op = OPENUM_LB;
                    3'd1:    w_op = OPENUM_LH;
                    3'd2:    w_op = OPENUM_LW;
                    3'd4:    w_op = OPENUM_LBU;
                    3'd5:    w_op = OPENUM_LHU;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPCODE_STORE: begin
                w_rd  = 5'd0;
                w_rs2 = i_inst[24:20];
                w_imm = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
                case (w_func3)
                    3'd0:    w_op = OPENUM_SB;
                    3'd1:    w_op = OPENUM_SH;
                    3'd2:    w_op = OPENUM_SW;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPCODE_BRANCH: begin
                w_rd  = 5'd0;
                w_rs2 = i_inst[24:20];
                w_imm = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
                case (w_func3)
                    3'd0:    w_op = OPENUM_BEQ;
                    3'd1:    w_op = OPENUM_BNE;
                    3'd4:    w_op = OPENUM_BLT;
                    3'd5:    w_op = OPENUM_BGE;
                    3'd6:    w_op = OPENUM_BLTU;
                    3'd7:    w_op = OPENUM_BGEU;
                    default: w_illegal = 1'b1;
                endcase
            end
            OPCODE_OP_IMM: begin
                w_imm = {{20{i_inst[31]}}, i_inst[31:20]};
                case (w_func3)
                    3'd0: w_op = OPENUM_ADDI;
                    3'd2: w_op = OPENUM_SLTI;
                    3'd3: w_op = OPENUM_SLTIU;
                    3'd4: w_op = OPENUM_XORI;
                    3'd6: w_op = OPENUM_ORI;
                    3'd7: w_op = OPENUM_ANDI;
                    3'd1: begin
                        w_op      = OPENUM_SLLI;
                        w_imm     = {27'd0, i_inst[24:20]};
                        w_illegal = (w_func7 != FUNC7_ZERO);
                    end
                    default: begin
                        w_op      = (w_func7 == FUNC7_ALT) ? OPENUM_SRAI : OPENUM_SRLI;
                        w_imm     = {27'd0, i_inst[24:20]};
                        w_illegal = (w_func7 != FUNC7_ZERO) && (w_func7 != FUNC7_ALT);
                    end
                endcase
            end
            OPCODE_OP: begin
                w_rs2 = i_inst[24:20];
                if (w_func7 == FUNC7_ZERO) begin
                    case (w_func3)
                        3'd0:    w_op = OPENUM_ADD;
                        3'd1:    w_op = OPENUM_SLL;
                        3'd2:    w_op = OPENUM_SLT;
                        3'd3:    w_op = OPENUM_SLTU;
                        3'd4:    w_op = OPENUM_XOR;
                        3'd5:    w_op = OPENUM_SRL;
                        3'd6:    w_op = OPENUM_OR;
                        default: w_op = OPENUM_AND;
                    endcase
                end else if (w_func7 == FUNC7_ALT) begin
                    case (w_func3)
                        3'd0:    w_op = OPENUM_SUB;
                        3'd5:    w_op = OPENUM_SRA;
                        default: w_illegal = 1'b1;
                    endcase
                end else if ((w_func7 == FUNC7_MUL) && ENABLE_M) begin
                    case (w_func3)
                        3'd0:    w_op = OPENUM_MUL;
                        3'd1:    w_op = OPENUM_MULH;
                        3'd2:    w_op = OPENUM_MULHSU;
                        3'd3:    w_op = OPENUM_MULHU;
                        3'd4:    w_op = OPENUM_DIV;
                        3'd5:    w_op = OPENUM_DIVU;
                        3'd6:    w_op = OPENUM_REM;
                        default: w_op = OPENUM_REMU;
                    endcase
                end else begin
                    w_illegal = 1'b1;
                end
            end
            OPCODE_FENCE: begin
                w_rd  = 5'd0;
                w_rs1 = 5'd0;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Illegal encodings leave no architectural footprint downstream.
    always_comb begin
        o_illegal = w_illegal;
        o_openum  = w_illegal ? OPENUM_NOP : w_op;
        o_rd      = w_illegal ? 5'd0 : w_rd;
        o_rs1     = w_illegal ? 5'd0 : w_rs1;
        o_rs2     = w_illegal ? 5'd0 : w_rs2;
        o_imm     = w_illegal ? 32'd0 : w_imm;
    end
endmodule
`default_nettype wire

// File: rtl/decode_queue.sv
`default_nettype none
// ============================================================================
//  Module      : decode_queue
//  Description : Circular fetch buffer feeding a registered decoded-op stage
//                with flush and global stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int PTR_W    = 4,
    parameter bit ENABLE_M = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rdy,
    input  logic           flush,
    decode_queue_if.slave  bus
);
    localparam logic [PTR_W:0]   C_FULL_COUNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   C_CNT_ONE    = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] C_PTR_ONE    = PTR_W'(1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic [31:0]        out_pc_q, out_pc_d;
    openum_t            out_openum_q, out_openum_d;
    reg_pos_t           out_rd_q, out_rd_d, out_rs1_q, out_rs1_d, out_rs2_q, out_rs2_d;
    logic [31:0]        out_imm_q, out_imm_d;
    logic               out_illegal_q, out_illegal_d;

    entry_t             w_head_entry;
    logic               w_in_ready, w_push, w_pop;
    openum_t            w_dec_openum;
    reg_pos_t           w_dec_rd, w_dec_rs1, w_dec_rs2;
    logic [31:0]        w_dec_imm;
    logic               w_dec_illegal;

    // in_ready looks only at the registered count: a full queue never
    // accepts, even when the head is popped in the same cycle.
    assign w_in_ready   = (count_q != C_FULL_COUNT) && !flush;
    assign w_push       = bus.in_valid && w_in_ready && rdy;
    assign w_pop        = rdy && (count_q != '0) && (!out_valid_q || bus.out_ready);
    assign w_head_entry = mem_q[head_q];

    inst_decode_core #(
        .ENABLE_M (ENABLE_M)
    ) u_core (
        .i_inst    (w_head_entry.inst),
        .o_openum  (w_dec_openum),
        .o_rd      (w_dec_rd),
        .o_rs1     (w_dec_rs1),
        .o_rs2     (w_dec_rs2),
        .o_imm     (w_dec_imm),
        .o_illegal (w_dec_illegal)
    );

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_openum_d  = out_openum_q;
        out_rd_d      = out_rd_q;
        out_rs1_d     = out_rs1_q;
        out_rs2_d     = out_rs2_q;
        out_imm_d     = out_imm_q;
        out_illegal_d = out_illegal_q;
        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            if (w_push) begin
                tail_d = tail_q + C_PTR_ONE;
            end
            if (w_pop) begin
                head_d        = head_q + C_PTR_ONE;
                out_valid_d   = 1'b1;
                out_pc_d      = w_head_entry.pc;
                out_openum_d  = w_dec_openum;
                out_rd_d      = w_dec_rd;
                out_rs1_d     = w_dec_rs1;
                out_rs2_d     = w_dec_rs2;
                out_imm_d     = w_dec_imm;
                out_illegal_d = w_dec_illegal;
            end else if (rdy && bus.out_ready) begin
                out_valid_d = 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            out_valid_q   <= 1'b0;
            out_pc_q      <= 32'd0;
            out_openum_q  <= OPENUM_NOP;
            out_rd_q      <= 5'd0;
            out_rs1_q     <= 5'd0;
            out_rs2_q     <= 5'd0;
            out_imm_q     <= 32'd0;
            out_illegal_q <= 1'b0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            out_valid_q   <= out_valid_d;
            out_pc_q      <= out_pc_d;
            out_openum_q  <= out_openum_d;
            out_rd_q      <= out_rd_d;
            out_rs1_q     <= out_rs1_d;
            out_rs2_q     <= out_rs2_d;
            out_imm_q     <= out_imm_d;
            out_illegal_q <= out_illegal_d;
        end
    end

    // Storage array carries no reset; occupancy is governed by the pointers.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            mem_q[tail_q] <= '{pc: bus.in_pc, inst: bus.in_inst};
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_pc      = out_pc_q;
    assign bus.out_openum  = out_openum_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_rs1     = out_rs1_q;
    assign bus.out_rs2     = out_rs2_q;
    assign bus.out_imm     = out_imm_q;
    assign bus.out_illegal = out_illegal_q;
endmodule
`default_nettype wire
